// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: synchronizes and filters the PS/2 clock, deframes
// 11-bit frames and presents validated scan codes with a ready/read handshake.
module ps2_keyboard #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clock50,
  input  logic       reset,
  input  logic       keyboard_clk,
  input  logic       keyboard_data,
  input  logic       read,
  output logic       scan_ready,
  output logic [7:0] scan_code
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned BW = 4;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t                state_q, state_n;
  logic                  kclk_s1_q, kclk_s2_q;
  logic                  kdat_s1_q, kdat_s2_q;
  logic [FILTER_LEN-1:0] hist_q;
  logic                  kclk_f_q, kclk_f_n;
  logic                  fall_c;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_n;
  logic [7:0]            shift_q, shift_n;
  logic                  parity_q, parity_n;
  logic [TW-1:0]         tmo_q, tmo_n;
  logic                  scan_ready_n;
  logic [7:0]            scan_code_n;

  // Synchronizers and clock-filter history; idle-high lines reset to 1.
  always_ff @(posedge clock50) begin
    if (!reset) begin
      kclk_s1_q <= 1'b1;
      kclk_s2_q <= 1'b1;
      kdat_s1_q <= 1'b1;
      kdat_s2_q <= 1'b1;
      hist_q    <= '1;
      kclk_f_q  <= 1'b1;
    end else begin
      kclk_s1_q <= keyboard_clk;
      kclk_s2_q <= kclk_s1_q;
      kdat_s1_q <= keyboard_data;
      kdat_s2_q <= kdat_s1_q;
      hist_q    <= {hist_q[FILTER_LEN-2:0], kclk_s2_q};
      kclk_f_q  <= kclk_f_n;
    end
  end

  // Filtered clock changes level only on a full run of identical samples.
  always_comb begin
    kclk_f_n = kclk_f_q;
    if (&hist_q) begin
      kclk_f_n = 1'b1;
    end else if (~|hist_q) begin
      kclk_f_n = 1'b0;
    end
  end

  assign fall_c = kclk_f_q & ~kclk_f_n;

  // Frame state, counters and output registers.
  always_ff @(posedge clock50) begin
    if (!reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tmo_q      <= '0;
      scan_ready <= 1'b0;
      scan_code  <= 8'h00;
    end else begin
      state_q    <= state_n;
      bit_cnt_q  <= bit_cnt_n;
      shift_q    <= shift_n;
      parity_q   <= parity_n;
      tmo_q      <= tmo_n;
      scan_ready <= scan_ready_n;
      scan_code  <= scan_code_n;
    end
  end

  // Next-state logic; a completing valid frame overrides a concurrent read.
  always_comb begin
    state_n      = state_q;
    bit_cnt_n    = bit_cnt_q;
    shift_n      = shift_q;
    parity_n     = parity_q;
    tmo_n        = tmo_q;
    scan_ready_n = scan_ready;
    scan_code_n  = scan_code;

    if (read) begin
      scan_ready_n = 1'b0;
    end
    if (state_q != IDLE) begin
      tmo_n = tmo_q + TW'(1);
    end

    if (fall_c) begin
      tmo_n = '0;
      case (state_q)
        IDLE: begin
          if (!kdat_s2_q) begin
            state_n   = DATA;
            bit_cnt_n = BW'(1);
          end
        end
        DATA: begin
          shift_n   = {kdat_s2_q, shift_q[7:1]};
          bit_cnt_n = bit_cnt_q + BW'(1);
          if (bit_cnt_q == BW'(8)) begin
            state_n = PARITY;
          end
        end
        PARITY: begin
          parity_n  = kdat_s2_q;
          bit_cnt_n = bit_cnt_q + BW'(1);
          state_n   = STOP;
        end
        STOP: begin
          state_n   = IDLE;
          bit_cnt_n = '0;
          if (((^shift_q) ^ parity_q) && kdat_s2_q) begin
            scan_code_n  = shift_q;
            scan_ready_n = 1'b1;
          end
        end
        default: begin
          state_n   = IDLE;
          bit_cnt_n = '0;
        end
      endcase
    end else if ((state_q != IDLE) && (tmo_q == TW'(TIMEOUT_CYCLES))) begin
      state_n   = IDLE;
      bit_cnt_n = '0;
      tmo_n     = '0;
    end
  end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Bench for ps2_keyboard: directed and random PS/2 frames against a
// frame-level model of received bits, validity and handshake.
module tb_ps2_keyboard;

  localparam int unsigned FL  = 8;
  localparam int unsigned TMO = 400;

  logic       clock50 = 1'b0;
  logic       reset = 1'b0;
  logic       keyboard_clk = 1'b1;
  logic       keyboard_data = 1'b1;
  logic       read = 1'b0;
  logic       scan_ready;
  logic [7:0] scan_code;

  ps2_keyboard #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
    .clock50      (clock50),
    .reset        (reset),
    .keyboard_clk (keyboard_clk),
    .keyboard_data(keyboard_data),
    .read         (read),
    .scan_ready   (scan_ready),
    .scan_code    (scan_code)
  );

  always #5 clock50 = ~clock50;

  int     checks = 0;
  int     failures = 0;
  int     cmp_prints = 0;
  longint cyc = 0;
  int     half = 30;
  bit     chk_en = 1'b0;

  always @(posedge clock50) cyc <= cyc + 1;

  // Frame-level reference: bits seen at falling edges, validated after 11.
  bit       exp_ready = 1'b0;
  bit [7:0] exp_code = 8'h00;
  bit       rx_bits[$];
  longint   last_edge = 0;
  bit       last_valid = 1'b0;

  function automatic void model_edge(input bit d);
    bit [7:0] b;
    last_valid = 1'b0;
    if (rx_bits.size() != 0 && (cyc - last_edge) >= longint'(TMO)) rx_bits.delete();
    last_edge = cyc;
    if (rx_bits.size() == 0 && d) return;
    rx_bits.push_back(d);
    if (rx_bits.size() == 11) begin
      for (int i = 0; i < 8; i++) b[i] = rx_bits[i+1];
      if (((^b) ^ rx_bits[9]) && rx_bits[10]) begin
        exp_code   = b;
        exp_ready  = 1'b1;
        last_valid = 1'b1;
      end
      rx_bits.delete();
    end
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Continuous comparison against the model outside edge-settling windows.
  always @(posedge clock50) begin
    #1;
    if (chk_en) begin
      checks++;
      if (scan_ready !== exp_ready || scan_code !== exp_code) begin
        failures++;
        if (cmp_prints < 20) begin
          cmp_prints++;
          $display("FAIL cmp t=%0t: ready=%b code=%h expected ready=%b code=%h",
                   $time, scan_ready, scan_code, exp_ready, exp_code);
        end
      end
    end
  end

  // mode 0: plain bit; 1: read pulse in the output-update cycle; 2: pin latency.
  task automatic ps2_bit(input bit d, input int mode);
    keyboard_data = d;
    repeat (half) @(negedge clock50);
    keyboard_clk = 1'b0;
    chk_en = 1'b0;
    model_edge(d);
    if (mode == 0) begin
      repeat (half) @(negedge clock50);
    end else begin
      repeat (FL + 2) @(negedge clock50);
      if (mode == 1) begin
        read = 1'b1;
        @(negedge clock50);
        read = 1'b0;
        if (!last_valid) exp_ready = 1'b0;
      end else begin
        check("lat_before", {7'd0, scan_ready}, 8'd0);
        @(negedge clock50);
        check("lat_ready", {7'd0, scan_ready}, 8'd1);
        check("lat_code", scan_code, 8'h1C);
      end
      repeat (half - int'(FL) - 3) @(negedge clock50);
    end
    keyboard_clk = 1'b1;
    chk_en = 1'b1;
  endtask

  task automatic send_frame(input bit [7:0] b, input bit flip, input bit stop,
                            input int last_mode = 0, input int nbits = 11);
    bit fb[11];
    fb[0] = 1'b0;
    for (int i = 0; i < 8; i++) fb[i+1] = b[i];
    fb[9]  = (~^b) ^ flip;
    fb[10] = stop;
    for (int i = 0; i < nbits; i++) ps2_bit(fb[i], (i == 10) ? last_mode : 0);
    keyboard_data = 1'b1;
    repeat (5) @(negedge clock50);
  endtask

  task automatic do_read();
    @(negedge clock50);
    read = 1'b1;
    exp_ready = 1'b0;
    @(negedge clock50);
    read = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clock50);
    reset = 1'b0;
    exp_ready = 1'b0;
    exp_code = 8'h00;
    rx_bits.delete();
    @(negedge clock50);
    reset = 1'b1;
  endtask

  initial begin
    repeat (4) @(negedge clock50);
    reset = 1'b1;
    check("rst_ready", {7'd0, scan_ready}, 8'd0);
    check("rst_code", scan_code, 8'h00);
    chk_en = 1'b1;
    repeat (20) @(negedge clock50);

    // 0x1C with pinned output latency.
    send_frame(8'h1C, 1'b0, 1'b1, 2);
    do_read();
    @(negedge clock50);
    check("read_clr", {7'd0, scan_ready}, 8'd0);
    check("read_hold", scan_code, 8'h1C);
    send_frame(8'hF0, 1'b0, 1'b1);
    check("f0_ready", {7'd0, scan_ready}, 8'd1);
    check("f0_code", scan_code, 8'hF0);
    do_read();

    // Error frames leave outputs alone.
    send_frame(8'h1C, 1'b1, 1'b1);
    check("par_ready", {7'd0, scan_ready}, 8'd0);
    check("par_code", scan_code, 8'hF0);
    send_frame(8'h32, 1'b0, 1'b0);
    check("stop_ready", {7'd0, scan_ready}, 8'd0);
    check("stop_code", scan_code, 8'hF0);
    send_frame(8'h32, 1'b0, 1'b1);
    check("v32_code", scan_code, 8'h32);
    do_read();

    // Short low pulse with data low must not start a frame.
    keyboard_data = 1'b0;
    @(negedge clock50);
    keyboard_clk = 1'b0;
    repeat (3) @(negedge clock50);
    keyboard_clk = 1'b1;
    repeat (30) @(negedge clock50);
    keyboard_data = 1'b1;
    send_frame(8'hA5, 1'b0, 1'b1);
    check("glitch_code", scan_code, 8'hA5);
    do_read();

    // Partial frame abandoned by timeout.
    send_frame(8'h5A, 1'b0, 1'b1, 0, 5);
    repeat (3 * TMO) @(negedge clock50);
    send_frame(8'h24, 1'b0, 1'b1);
    check("tmo_code", scan_code, 8'h24);
    check("tmo_ready", {7'd0, scan_ready}, 8'd1);

    // Overrun then collision of read with frame completion.
    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'h32, 1'b0, 1'b1);
    check("ovr_code", scan_code, 8'h32);
    check("ovr_ready", {7'd0, scan_ready}, 8'd1);
    send_frame(8'h77, 1'b0, 1'b1, 1);
    check("coll_ready", {7'd0, scan_ready}, 8'd1);
    check("coll_code", scan_code, 8'h77);

    // Reset mid-frame.
    send_frame(8'h99, 1'b0, 1'b1, 0, 4);
    pulse_reset();
    @(negedge clock50);
    check("mrst_ready", {7'd0, scan_ready}, 8'd0);
    check("mrst_code", scan_code, 8'h00);
    send_frame(8'h1C, 1'b0, 1'b1);
    check("post_rst_code", scan_code, 8'h1C);

    // Randomized frames, corruption, reads and collisions.
    for (int n = 0; n < 40; n++) begin
      half = int'($urandom_range(20, 40));
      send_frame(8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 5) == 0) ? 1 : 0);
      if ($urandom_range(0, 1) == 1) do_read();
      repeat ($urandom_range(5, 100)) @(negedge clock50);
    end

    repeat (20) @(negedge clock50);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
